// File: rtl/cmos_frame_gen_if.sv
// Frame-memory read port and CMOS-style video output of cmos_frame_gen.
// The generator drives the master side; the memory and the video sink use the slave side.
interface cmos_frame_gen_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [23:0]       mem_data;
    logic              cmos_vsync;
    logic              cmos_href;
    logic              cmos_clken;
    logic [23:0]       cmos_data;
    logic [10:0]       x_pos;
    logic [10:0]       y_pos;

    modport master (
        output mem_addr, mem_rd,
        input  mem_data,
        output cmos_vsync, cmos_href, cmos_clken, cmos_data, x_pos, y_pos
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_data,
        input  cmos_vsync, cmos_href, cmos_clken, cmos_data, x_pos, y_pos
    );
endinterface

// File: rtl/cmos_frame_gen.sv
// CMOS sensor frame emulator: vsync/href/clken timing, pixel-rate divider and
// pixel data from an external frame memory or an internal pattern source.
//   state       | meaning
//   S_IDLE      | stopped, vsync low, waiting for start
//   S_RUN       | free-running frames
//   S_STOP_PEND | finish the current frame, then return to S_IDLE
module cmos_frame_gen #(
    parameter int H_DISP  = 640,
    parameter int V_DISP  = 480,
    parameter int H_SYNC  = 5,
    parameter int H_BACK  = 5,
    parameter int H_FRONT = 5,
    parameter int V_SYNC  = 1,
    parameter int V_BACK  = 0,
    parameter int V_FRONT = 1,
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        single_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] solid_color_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o,
    cmos_frame_gen_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        single_q, single_d;
    logic [15:0] div_q, div_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] solid_q, solid_d;
    logic        busy, tick, h_last, v_last, eof;

    function automatic logic in_active(input logic [15:0] h, input logic [15:0] v);
        return (h >= 16'(H_ACT0)) && (h < 16'(H_ACT0 + H_DISP)) &&
               (v >= 16'(V_ACT0)) && (v < 16'(V_ACT0 + V_DISP));
    endfunction

    function automatic logic [2:0] bar_of(input logic [10:0] x);
        logic [2:0] b;
        b = '0;
        for (int k = 1; k < 8; k++) begin
            if ({x, 3'b000} >= 14'(k * H_DISP)) b = 3'(k);
        end
        return b;
    endfunction

    assign busy   = (state_q != S_IDLE);
    assign tick   = busy && (div_q == DIV_LAST);
    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);
    assign eof    = tick && h_last && v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            single_q <= 1'b0;
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            mode_q   <= '0;
            solid_q  <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        mode_d   = mode_q;
        solid_d  = solid_q;

        if (busy) div_d = tick ? '0 : div_q + 16'd1;
        if (tick) begin
            hcnt_d = h_last ? '0 : hcnt_q + 16'd1;
            if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 16'd1;
            // Pattern selection only changes on frame boundaries.
            if (hcnt_q == '0 && vcnt_q == '0) begin
                mode_d  = mode_i;
                solid_d = solid_color_i;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    single_d = single_i;
                    div_d    = '0;
                    hcnt_d   = '0;
                    vcnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop_i || single_q) state_d = eof ? S_IDLE : S_STOP_PEND;
            end
            S_STOP_PEND: begin
                if (eof) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The memory answers one clk after mem_rd, so the read is issued from the
    // next-state counters to land in step with the stage-2 outputs.
    logic              act_n, rd_n;
    logic [10:0]       x_n, y_n;
    logic [ADDR_W-1:0] addr_n;

    always_comb begin
        act_n  = in_active(hcnt_d, vcnt_d);
        x_n    = act_n ? 11'(hcnt_d - 16'(H_ACT0)) : '0;
        y_n    = act_n ? 11'(vcnt_d - 16'(V_ACT0)) : '0;
        rd_n   = act_n && (state_d != S_IDLE) && (div_d == DIV_LAST) && (mode_d == 2'd0);
        addr_n = rd_n ? ADDR_W'(32'(y_n) * 32'(H_DISP) + 32'(x_n)) : '0;
    end

    logic        act0, vsync0;
    logic [10:0] x0, y0;
    logic [23:0] pat0;

    always_comb begin
        act0   = busy && in_active(hcnt_q, vcnt_q);
        vsync0 = busy && (vcnt_q >= 16'(V_SYNC));
        x0     = act0 ? 11'(hcnt_q - 16'(H_ACT0)) : '0;
        y0     = act0 ? 11'(vcnt_q - 16'(V_ACT0)) : '0;
        pat0   = '0;
        case (mode_q)
            2'd1: begin
                case (bar_of(x0))
                    3'd0:    pat0 = 24'hFFFFFF;
                    3'd1:    pat0 = 24'hFFFF00;
                    3'd2:    pat0 = 24'h00FFFF;
                    3'd3:    pat0 = 24'h00FF00;
                    3'd4:    pat0 = 24'hFF00FF;
                    3'd5:    pat0 = 24'hFF0000;
                    3'd6:    pat0 = 24'h0000FF;
                    default: pat0 = 24'h000000;
                endcase
            end
            2'd2:    pat0 = {3{x0[7:0]}};
            2'd3:    pat0 = solid_q;
            default: pat0 = '0;
        endcase
    end

    logic              href_s1, vsync_s1, clken_s1, eof_s1, mem_sel_s1, rd_s1;
    logic [10:0]       x_s1, y_s1;
    logic [23:0]       pat_s1;
    logic [ADDR_W-1:0] addr_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_s1    <= 1'b0;
            vsync_s1   <= 1'b0;
            clken_s1   <= 1'b0;
            eof_s1     <= 1'b0;
            mem_sel_s1 <= 1'b0;
            rd_s1      <= 1'b0;
            x_s1       <= '0;
            y_s1       <= '0;
            pat_s1     <= '0;
            addr_s1    <= '0;
        end else begin
            href_s1    <= act0;
            vsync_s1   <= vsync0;
            clken_s1   <= act0 && tick;
            eof_s1     <= eof;
            mem_sel_s1 <= (mode_q == 2'd0);
            rd_s1      <= rd_n;
            x_s1       <= x0;
            y_s1       <= y0;
            pat_s1     <= pat0;
            addr_s1    <= addr_n;
        end
    end

    logic        href_q, vsync_q, clken_q, done_q, busy_q;
    logic [10:0] x_q, y_q;
    logic [23:0] data_q, data_d;
    logic [15:0] frame_cnt_q;

    // Memory data is only valid on the clken clk; hold it across the pixel.
    always_comb begin
        data_d = '0;
        if (href_s1) data_d = mem_sel_s1 ? (clken_s1 ? bus.mem_data : data_q) : pat_s1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            clken_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            data_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            href_q  <= href_s1;
            vsync_q <= vsync_s1;
            clken_q <= clken_s1;
            done_q  <= eof_s1;
            busy_q  <= busy;
            x_q     <= x_s1;
            y_q     <= y_s1;
            data_q  <= data_d;
            if (eof_s1) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.mem_addr   = addr_s1;
    assign bus.mem_rd     = rd_s1;
    assign bus.cmos_vsync = vsync_q;
    assign bus.cmos_href  = href_q;
    assign bus.cmos_clken = clken_q;
    assign bus.cmos_data  = data_q;
    assign bus.x_pos      = x_q;
    assign bus.y_pos      = y_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign frame_cnt_o    = frame_cnt_q;
endmodule

// File: tb/tb_cmos_frame_gen.sv
// Directed bench for cmos_frame_gen on an 8x4 frame (12x7 total): gradient,
// memory, stop, mode change, reset mid-frame, and a CLK_DIV=1 instance.
module tb_cmos_frame_gen;
    localparam int ADDR_W = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 0, stop1 = 0, single1 = 0;
    logic [1:0]  mode1 = 0;
    logic [23:0] solid1 = 0;
    logic        busy1, done1;
    logic [15:0] cnt1;
    logic        start2 = 0, stop2 = 0, single2 = 0;
    logic [1:0]  mode2 = 0;
    logic [23:0] solid2 = 0;
    logic        busy2, done2;
    logic [15:0] cnt2;

    cmos_frame_gen_if #(.ADDR_W(ADDR_W)) bus1 ();
    cmos_frame_gen_if #(.ADDR_W(ADDR_W)) bus2 ();

    cmos_frame_gen #(
        .H_DISP(8), .V_DISP(4), .H_SYNC(2), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLK_DIV(2), .ADDR_W(ADDR_W)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .stop_i(stop1), .single_i(single1),
        .mode_i(mode1), .solid_color_i(solid1), .busy_o(busy1), .frame_done_o(done1),
        .frame_cnt_o(cnt1), .bus(bus1)
    );

    cmos_frame_gen #(
        .H_DISP(8), .V_DISP(4), .H_SYNC(2), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLK_DIV(1), .ADDR_W(ADDR_W)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .stop_i(stop2), .single_i(single2),
        .mode_i(mode2), .solid_color_i(solid2), .busy_o(busy2), .frame_done_o(done2),
        .frame_cnt_o(cnt2), .bus(bus2)
    );

    // Frame memory: addr -> {addr, addr, addr}, one clk read latency.
    always @(posedge clk) if (bus1.mem_rd) bus1.mem_data <= {3{bus1.mem_addr[7:0]}};
    always @(posedge clk) if (bus2.mem_rd) bus2.mem_data <= {3{bus2.mem_addr[7:0]}};

    logic [23:0]       data_log[$];
    logic [21:0]       xy_log[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                done_neg2[$];
    int negcnt = 0, done_cnt1 = 0, href_cnt1 = 0, clken_cnt2 = 0, eqv_err2 = 0;

    always @(negedge clk) begin
        negcnt <= negcnt + 1;
        if (bus1.cmos_clken) begin
            data_log.push_back(bus1.cmos_data);
            xy_log.push_back({bus1.x_pos, bus1.y_pos});
        end
        if (bus1.mem_rd) addr_log.push_back(bus1.mem_addr);
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (bus1.cmos_href) href_cnt1 <= href_cnt1 + 1;
        if (bus2.cmos_clken) clken_cnt2 <= clken_cnt2 + 1;
        if (bus2.cmos_clken != bus2.cmos_href) eqv_err2 <= eqv_err2 + 1;
        if (done2) done_neg2.push_back(negcnt + 1);
    end

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start1 = 0; stop1 = 0; single1 = 0;
        start2 = 0; stop2 = 0; single2 = 0;
        rst_n = 0;
        step(2);
        rst_n = 1;
        step(1);
    endtask

    // Start a single gradient frame (edge 0) and check timing and content.
    task automatic run_gradient_frame(input string tag);
        int db, dn;
        db = data_log.size();
        dn = done_cnt1;
        mode1 = 2; single1 = 1; start1 = 1;
        step(1);
        start1 = 0; single1 = 0;
        step(25);
        check({tag, "_vsync_pre"}, bus1.cmos_vsync, 0);
        step(1);
        check({tag, "_vsync_rise"}, bus1.cmos_vsync, 1);
        step(142);
        check({tag, "_busy_168"}, busy1, 1);
        step(1);
        check({tag, "_busy_169"}, busy1, 0);
        check({tag, "_done_pulse"}, done1, 1);
        check({tag, "_frame_cnt"}, cnt1, 1);
        step(3);
        check({tag, "_vsync_idle"}, bus1.cmos_vsync, 0);
        check({tag, "_clken_cnt"}, data_log.size() - db, 32);
        check({tag, "_done_cnt"}, done_cnt1 - dn, 1);
        for (int i = 0; i < 32; i++) begin
            check({tag, "_data"}, data_log[db + i], {3{8'(i % 8)}});
            check({tag, "_xy"}, xy_log[db + i], {11'(i % 8), 11'(i / 8)});
        end
    endtask

    initial begin
        int db, ab, hb, n0, nd, cb, eb;

        do_reset();
        check("rst_ctrl", {bus1.cmos_vsync, bus1.cmos_href, bus1.cmos_clken, bus1.mem_rd, busy1, done1}, 0);
        check("rst_data", bus1.cmos_data, 0);
        check("rst_xy", {bus1.x_pos, bus1.y_pos}, 0);
        check("rst_addr", bus1.mem_addr, 0);
        check("rst_cnt", cnt1, 0);

        run_gradient_frame("grad");

        // Memory mode
        do_reset();
        db = data_log.size();
        ab = addr_log.size();
        mode1 = 0; single1 = 1; start1 = 1;
        step(1);
        start1 = 0; single1 = 0;
        step(180);
        check("mem_rd_cnt", addr_log.size() - ab, 32);
        check("mem_clken_cnt", data_log.size() - db, 32);
        check("mem_frame_cnt", cnt1, 1);
        for (int i = 0; i < 32; i++) begin
            check("mem_addr", addr_log[ab + i], i);
            check("mem_data", data_log[db + i], {3{8'(i)}});
            check("mem_xy", xy_log[db + i], {11'(i % 8), 11'(i / 8)});
        end

        // Stop at clk 50 of frame 2
        do_reset();
        db = data_log.size();
        mode1 = 2; start1 = 1;
        step(1);
        start1 = 0;
        step(217);
        stop1 = 1;
        step(1);
        stop1 = 0;
        step(118);
        check("stop_done_336", done1, 0);
        step(1);
        check("stop_done_337", done1, 1);
        check("stop_busy", busy1, 0);
        check("stop_cnt", cnt1, 2);
        hb = href_cnt1;
        step(200);
        check("stop_no_href", href_cnt1 - hb, 0);
        check("stop_cnt_hold", cnt1, 2);
        check("stop_clken_cnt", data_log.size() - db, 64);

        // Colour bar -> solid mid-frame
        do_reset();
        db = data_log.size();
        mode1 = 1; solid1 = 24'hABCDEF; start1 = 1;
        step(1);
        start1 = 0;
        step(79);
        mode1 = 3; solid1 = 24'h123456;
        step(120);
        stop1 = 1;
        step(1);
        stop1 = 0;
        step(150);
        check("mode_cnt", cnt1, 2);
        check("mode_clken_cnt", data_log.size() - db, 64);
        for (int i = 0; i < 64; i++)
            check("mode_data", data_log[db + i], (i < 32) ? bars[i % 8] : 24'h123456);

        // Reset mid-frame, then restart
        do_reset();
        mode1 = 2; single1 = 1; start1 = 1;
        step(1);
        start1 = 0; single1 = 0;
        step(89);
        check("pre_rst_busy", busy1, 1);
        rst_n = 0;
        #1;
        check("midrst_ctrl", {bus1.cmos_vsync, bus1.cmos_href, bus1.cmos_clken, bus1.mem_rd, busy1, done1}, 0);
        check("midrst_data", bus1.cmos_data, 0);
        check("midrst_xy", {bus1.x_pos, bus1.y_pos}, 0);
        check("midrst_cnt", cnt1, 0);
        step(2);
        rst_n = 1;
        step(1);
        run_gradient_frame("rerun");

        // CLK_DIV=1 instance
        do_reset();
        nd = done_neg2.size();
        cb = clken_cnt2;
        eb = eqv_err2;
        mode2 = 2; start2 = 1;
        step(1);
        start2 = 0;
        n0 = negcnt;
        step(39);
        start2 = 1; single2 = 1;
        step(1);
        start2 = 0; single2 = 0;
        step(59);
        stop2 = 1;
        step(1);
        stop2 = 0;
        step(80);
        check("div1_done_cnt", done_neg2.size() - nd, 2);
        check("div1_first_done", done_neg2[nd] - n0, 86);
        check("div1_frame_len", done_neg2[nd + 1] - done_neg2[nd], 84);
        check("div1_frame_cnt", cnt2, 2);
        check("div1_clken_cnt", clken_cnt2 - cb, 64);
        check("div1_clken_eq_href", eqv_err2 - eb, 0);
        check("div1_busy", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmos_frame_gen.md
# cmos_frame_gen

Synthesizable CMOS-sensor frame emulator and the parametrised successor of our BMP-driven bench stimulus. Produces OV7725/OV5640-style `vsync`/`href`/`clken` timing with programmable geometry and blanking, and a pixel-rate divider. Pixel data comes from an external synchronous frame memory or an internal pattern source. It feeds the VIP chain (RGB→YCbCr, binarization, Sobel) on-board and in simulation, and supports run-until-stop or single-frame capture.

## Interface
- `H_DISP`, 640, active pixels per line
- `V_DISP`, 480, active lines per frame
- `H_SYNC` / `H_BACK` / `H_FRONT`, 5 / 5 / 5, horizontal blanking in pixel ticks
- `V_SYNC` / `V_BACK` / `V_FRONT`, 1 / 0 / 1, vertical blanking in lines
- `CLK_DIV`, 2, clk cycles per pixel tick (≥1)
- `ADDR_W`, 20, memory address width (≥ clog2(H_DISP·V_DISP))
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-clk request to begin; ignored unless IDLE
- `stop`  in  1  one-clk request; finish current frame, then IDLE
- `single`  in  1  sampled with `start`; 1 = one frame only
- `mode`  in  2  0 memory, 1 colour bar, 2 gradient, 3 solid
- `solid_color`  in  24  RGB used in mode 3
- `mem_addr`  out  ADDR_W  pixel address y·H_DISP+x
- `mem_rd`  out  1  read strobe, one clk per active pixel
- `mem_data`  in  24  RGB; valid exactly 1 clk after `mem_rd`
- `cmos_vsync`  out  1  low during V_SYNC lines and in IDLE, else high
- `cmos_href`  out  1  high over active pixels
- `cmos_clken`  out  1  pixel qualifier = href & delayed tick
- `cmos_data`  out  24  {R[23:16], G[15:8], B[7:0]}
- `x_pos`, `y_pos`  out  11  active coordinates aligned with data; 0 outside active region
- `busy`  out  1  high in RUN or STOP_PEND
- `frame_done`  out  1  one-clk pulse at end of each completed frame
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT. V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT.
- States:
  - IDLE: `start` → RUN; clear `div`, `hcnt`, `vcnt`; latch `single`.
  - RUN: `stop`, or latched `single` → STOP_PEND. `start` is ignored.
  - STOP_PEND: on the last tick of the frame → IDLE.
  - `stop` and `start` in the same clk in IDLE: `start` wins; `stop` is ignored.
- Tick divider: `div` counts 0..CLK_DIV-1; `tick` = busy & (div == CLK_DIV-1).
- Counters advance only on `tick`. `hcnt` wraps at H_TOTAL-1; `vcnt` increments on `hcnt` wrap and wraps at V_TOTAL-1.
- Active region: vcnt ∈ [V_SYNC+V_BACK, +V_DISP) and hcnt ∈ [H_SYNC+H_BACK, +H_DISP). x = hcnt-(H_SYNC+H_BACK); y likewise.
- `mode` and `solid_color` are latched at (hcnt=0, vcnt=0, tick). Mid-frame changes apply from the next frame.
- Patterns:
  - Colour bar: bar index = x·8/H_DISP. Bars in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Gradient: R=G=B=x[7:0].
  - Solid: `solid_color`.
- End of frame: last tick with hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1. Pulse `frame_done` and increment `frame_cnt` (aligned with stage-2 outputs).
- Memory is read only in mode 0. `mem_rd` stays 0 in other modes.

## Timing
- Reset values: all outputs 0; state IDLE; `frame_cnt`=0.
- Two-stage pipeline from counter state (stage 0):
  - Stage 1 registers `mem_addr`, `mem_rd`, and the control/position signals.
  - Stage 2 registers `cmos_data` (from `mem_data` or the pattern), `cmos_href`, `cmos_vsync`, `cmos_clken`, `x_pos`, `y_pos`.
  - All stage-2 outputs are mutually aligned.
- With CLK_DIV≥2, `cmos_clken` is a single-clk pulse every CLK_DIV clks while `href` is high. With CLK_DIV=1, `cmos_clken`=`href`.
- `href` stays high continuously for H_DISP·CLK_DIV clks per active line.
- After `start`, the first `vsync` rise occurs (V_SYNC·H_TOTAL·CLK_DIV)+2 clks later.
- After STOP_PEND→IDLE, `busy` drops in the same clk as `frame_done`. The outputs drain over 2 clks; `vsync` then goes low.
- `rst_n` asserted mid-frame: immediate IDLE, outputs 0. The partial frame is not counted.

## Test plan
Params for all scenarios: H_DISP=8, V_DISP=4, H_SYNC=2, H_BACK=1, H_FRONT=1, V_SYNC=1, V_BACK=1, V_FRONT=1, CLK_DIV=2. This gives H_TOTAL=12, V_TOTAL=7, 168 clk per frame.

- **Single frame, gradient:** `start`+`single`, mode 2 → exactly 32 `clken` pulses, data 000000..070707 per line, one `frame_done`, `frame_cnt`=1, `busy` low after 168 clk.
- **Memory mode:** RAM holds addr→{addr,addr,addr} → `mem_addr` 0..31 in order. `cmos_data` equals RAM content at each `clken`; `x_pos`/`y_pos` match.
- **Stop mid-frame:** continuous run, `stop` at clk 50 of frame 2 → frame 2 completes; `frame_cnt`=2; no further `href`.
- **Mode change mid-frame:** switch 1→3 mid-frame → the rest of the frame stays colour bar (bar width 1 px, 8 colours in order); the next frame is all `solid_color`.
- **Reset mid-frame, then restart:** assert `rst_n` low at clk 90 → all outputs 0 within the reset. After release plus `start`, timing matches the single-frame scenario; `frame_cnt` counts from 0.
- **CLK_DIV=1 regression:** `clken`≡`href`; frame is 84 clk long; `start` during RUN is ignored with no counter disturbance.
